// File: rtl/float_add_pipe.sv
// float_add_pipe: four-stage pipelined add/subtract for the custom
// {sign, biased exponent, fraction} float format. The stages are compare,
// align, add/leading-zero count, and normalise. A final register rounds,
// checks the exponent range and packs the result.
module float_add_pipe #(
    parameter int EXP_W    = 5,
    parameter int MAN_W    = 6,
    parameter int ROUND_EN = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    input  logic                   sub,
    input  logic [EXP_W+MAN_W:0]   fp_a,
    input  logic [EXP_W+MAN_W:0]   fp_b,
    output logic                   out_valid,
    output logic [EXP_W+MAN_W:0]   fp_x,
    output logic                   overflow,
    output logic                   underflow
);
    localparam int SIG_W   = MAN_W + 4;           // {1, frac, G, R, St}
    localparam int E2_W    = EXP_W + 2;           // two's complement exponent
    localparam int LZ_W    = $clog2(SIG_W + 1);
    localparam int EXP_MAX = (1 << EXP_W) - 1;

    // ---------------- S1: operand ordering ----------------
    logic               s1_valid_reg, s1_sign_reg, s1_eff_sub_reg;
    logic [EXP_W-1:0]   s1_exp_reg, s1_diff_reg;
    logic [MAN_W:0]     s1_sig_l_reg, s1_sig_s_reg;

    logic               sign_b;
    logic [EXP_W-1:0]   exp_a, exp_b;
    logic [MAN_W:0]     sig_a, sig_b;
    logic               a_is_l;

    // Decode both operands and pick the larger magnitude as L.
    always_comb begin
        sign_b = fp_b[EXP_W+MAN_W] ^ sub;
        exp_a  = fp_a[EXP_W+MAN_W-1:MAN_W];
        exp_b  = fp_b[EXP_W+MAN_W-1:MAN_W];
        sig_a  = (exp_a != '0) ? {1'b1, fp_a[MAN_W-1:0]} : '0;
        sig_b  = (exp_b != '0) ? {1'b1, fp_b[MAN_W-1:0]} : '0;
        a_is_l = fp_a[EXP_W+MAN_W-1:0] >= fp_b[EXP_W+MAN_W-1:0];
    end

    // Register the ordered operands and the exponent difference.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_reg   <= 1'b0;
            s1_sign_reg    <= 1'b0;
            s1_eff_sub_reg <= 1'b0;
            s1_exp_reg     <= '0;
            s1_diff_reg    <= '0;
            s1_sig_l_reg   <= '0;
            s1_sig_s_reg   <= '0;
        end else begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_eff_sub_reg <= fp_a[EXP_W+MAN_W] ^ sign_b;
                if (a_is_l) begin
                    s1_sign_reg  <= fp_a[EXP_W+MAN_W];
                    s1_exp_reg   <= exp_a;
                    s1_diff_reg  <= exp_a - exp_b;
                    s1_sig_l_reg <= sig_a;
                    s1_sig_s_reg <= sig_b;
                end else begin
                    s1_sign_reg  <= sign_b;
                    s1_exp_reg   <= exp_b;
                    s1_diff_reg  <= exp_b - exp_a;
                    s1_sig_l_reg <= sig_b;
                    s1_sig_s_reg <= sig_a;
                end
            end
        end
    end

    // ---------------- S2: alignment ----------------
    logic               s2_valid_reg, s2_sign_reg, s2_eff_sub_reg;
    logic [EXP_W-1:0]   s2_exp_reg;
    logic [SIG_W-1:0]   s2_sig_l_reg, s2_sig_s_reg;

    logic [SIG_W-1:0]   s_ext, s_shift, s_lost, s_aligned;

    // Shift S right by the exponent difference, folding lost bits into sticky.
    always_comb begin
        s_ext     = {s1_sig_s_reg, 3'b000};
        s_shift   = '0;
        s_lost    = '0;
        s_aligned = '0;
        if (int'(s1_diff_reg) >= MAN_W + 3) begin
            s_aligned = {{(SIG_W-1){1'b0}}, |s_ext};
        end else begin
            s_shift   = s_ext >> s1_diff_reg;
            s_lost    = s_ext & ~({SIG_W{1'b1}} << s1_diff_reg);
            s_aligned = {s_shift[SIG_W-1:1], s_shift[0] | (|s_lost)};
        end
    end

    // Register the aligned significands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid_reg   <= 1'b0;
            s2_sign_reg    <= 1'b0;
            s2_eff_sub_reg <= 1'b0;
            s2_exp_reg     <= '0;
            s2_sig_l_reg   <= '0;
            s2_sig_s_reg   <= '0;
        end else begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_sign_reg    <= s1_sign_reg;
                s2_eff_sub_reg <= s1_eff_sub_reg;
                s2_exp_reg     <= s1_exp_reg;
                s2_sig_l_reg   <= {s1_sig_l_reg, 3'b000};
                s2_sig_s_reg   <= s_aligned;
            end
        end
    end

    // ---------------- S3: add/subtract and leading-zero count ----------------
    logic               s3_valid_reg, s3_sign_reg;
    logic [EXP_W-1:0]   s3_exp_reg;
    logic [SIG_W:0]     s3_sum_reg;
    logic [LZ_W-1:0]    s3_lzc_reg;

    logic [SIG_W:0]     sum_next;
    logic [LZ_W-1:0]    lzc_next;

    // L >= S always holds, so the subtraction never goes negative.
    always_comb begin
        if (s2_eff_sub_reg)
            sum_next = {1'b0, s2_sig_l_reg} - {1'b0, s2_sig_s_reg};
        else
            sum_next = {1'b0, s2_sig_l_reg} + {1'b0, s2_sig_s_reg};
        lzc_next = LZ_W'(SIG_W);
        for (int i = 0; i < SIG_W; i++) begin
            if (sum_next[i]) lzc_next = LZ_W'(SIG_W - 1 - i);
        end
    end

    // Register the raw sum and its leading-zero count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s3_valid_reg <= 1'b0;
            s3_sign_reg  <= 1'b0;
            s3_exp_reg   <= '0;
            s3_sum_reg   <= '0;
            s3_lzc_reg   <= '0;
        end else begin
            s3_valid_reg <= s2_valid_reg;
            if (s2_valid_reg) begin
                s3_sign_reg <= s2_sign_reg;
                s3_exp_reg  <= s2_exp_reg;
                s3_sum_reg  <= sum_next;
                s3_lzc_reg  <= lzc_next;
            end
        end
    end

    // ---------------- S4: normalisation ----------------
    logic               s4_valid_reg, s4_sign_reg, s4_zero_reg;
    logic [E2_W-1:0]    s4_exp_reg;
    logic [SIG_W-1:0]   s4_norm_reg;

    logic [E2_W-1:0]    exp_norm;
    logic [SIG_W-1:0]   sig_norm;

    // Exponents are carried as E2_W-bit two's complement so that range
    // violations stay visible after the +1/-lzc adjustments.
    always_comb begin
        if (s3_sum_reg[SIG_W]) begin
            sig_norm = {s3_sum_reg[SIG_W:2], s3_sum_reg[1] | s3_sum_reg[0]};
            exp_norm = {2'b00, s3_exp_reg} + E2_W'(1);
        end else begin
            sig_norm = s3_sum_reg[SIG_W-1:0] << s3_lzc_reg;
            exp_norm = {2'b00, s3_exp_reg} - {{(E2_W-LZ_W){1'b0}}, s3_lzc_reg};
        end
    end

    // Register the normalised significand and exponent.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s4_valid_reg <= 1'b0;
            s4_sign_reg  <= 1'b0;
            s4_zero_reg  <= 1'b0;
            s4_exp_reg   <= '0;
            s4_norm_reg  <= '0;
        end else begin
            s4_valid_reg <= s3_valid_reg;
            if (s3_valid_reg) begin
                s4_sign_reg <= s3_sign_reg;
                s4_zero_reg <= (s3_sum_reg == '0);
                s4_exp_reg  <= exp_norm;
                s4_norm_reg <= sig_norm;
            end
        end
    end

    // ---------------- Round, range check and pack ----------------
    logic                 round_up;
    logic [MAN_W+1:0]     mant_r;
    logic [E2_W-1:0]      exp_r;
    logic [MAN_W-1:0]     frac_r;
    logic [EXP_W+MAN_W:0] x_next;
    logic                 of_next, uf_next;

    // Round the normalised value, then saturate or flush by final exponent.
    always_comb begin
        round_up = (ROUND_EN != 0) && s4_norm_reg[2] &&
                   (s4_norm_reg[1] || s4_norm_reg[0] || s4_norm_reg[3]);
        mant_r   = {1'b0, s4_norm_reg[SIG_W-1:3]} + {{(MAN_W+1){1'b0}}, round_up};
        if (mant_r[MAN_W+1]) begin
            exp_r  = s4_exp_reg + E2_W'(1);
            frac_r = '0;
        end else begin
            exp_r  = s4_exp_reg;
            frac_r = mant_r[MAN_W-1:0];
        end
        x_next  = '0;
        of_next = 1'b0;
        uf_next = 1'b0;
        if (s4_zero_reg) begin
            x_next = '0;
        end else if (!exp_r[E2_W-1] && (exp_r[E2_W-2:0] > (E2_W-1)'(EXP_MAX))) begin
            x_next  = {s4_sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
            of_next = 1'b1;
        end else if (exp_r[E2_W-1] || (exp_r == '0)) begin
            uf_next = 1'b1;
        end else begin
            x_next = {s4_sign_reg, exp_r[EXP_W-1:0], frac_r};
        end
    end

    // Output register: result holds between valids, flags only pulse with valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            fp_x      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            out_valid <= s4_valid_reg;
            overflow  <= s4_valid_reg & of_next;
            underflow <= s4_valid_reg & uf_next;
            if (s4_valid_reg) fp_x <= x_next;
        end
    end
endmodule

// File: tb/tb_float_add_pipe.sv
// Directed testbench for float_add_pipe (EXP_W=5, MAN_W=6). A rounding and
// a truncating instance share the same stimulus.
module tb_float_add_pipe;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        sub;
    logic [11:0] fp_a, fp_b;
    logic        out_valid, overflow, underflow;
    logic [11:0] fp_x;
    logic        t_out_valid, t_overflow, t_underflow;
    logic [11:0] t_fp_x;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    float_add_pipe #(.EXP_W(5), .MAN_W(6), .ROUND_EN(1)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .sub(sub),
        .fp_a(fp_a), .fp_b(fp_b), .out_valid(out_valid), .fp_x(fp_x),
        .overflow(overflow), .underflow(underflow)
    );

    float_add_pipe #(.EXP_W(5), .MAN_W(6), .ROUND_EN(0)) dut_trunc (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .sub(sub),
        .fp_a(fp_a), .fp_b(fp_b), .out_valid(t_out_valid), .fp_x(t_fp_x),
        .overflow(t_overflow), .underflow(t_underflow)
    );

    // Issue one operation and capture the first result that appears.
    task automatic op(input logic [11:0] a, input logic [11:0] b, input logic s,
                      output int lat, output logic [11:0] x, output logic of,
                      output logic uf, output logic [11:0] xt);
        lat = 0; x = '0; of = 1'b0; uf = 1'b0; xt = '0;
        @(negedge clk);
        in_valid = 1'b1; fp_a = a; fp_b = b; sub = s;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = k; x = fp_x; of = overflow; uf = underflow; xt = t_fp_x;
                break;
            end
        end
        $display("op a=%03h b=%03h sub=%0d -> lat=%0d x=%03h of=%0d uf=%0d trunc=%03h",
                 a, b, s, lat, x, of, uf, xt);
    endtask

    task automatic test_reset();
        int seen;
        reset_n = 1'b0; in_valid = 1'b0; sub = 1'b0; fp_a = '0; fp_b = '0;
        #2;
        n_checks++;
        if (out_valid !== 1'b0 || fp_x !== 12'h000 || overflow !== 1'b0 || underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b x=%03h of=%b uf=%b, required all 0",
                     out_valid, fp_x, overflow, underflow);
        end
        repeat (3) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        seen = 0;
        repeat (6) begin @(posedge clk); #1; if (out_valid !== 1'b0) seen++; end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL reset_idle: got %0d valid cycles, required 0", seen);
        end
        $display("reset: idle cycles with out_valid=%0d", seen);
    endtask

    task automatic test_basic();
        int lat; logic [11:0] x, xt; logic of, uf;
        op(12'h3C0, 12'h3C0, 1'b0, lat, x, of, uf, xt);
        n_checks++;
        if (lat !== 4) begin n_fail++; $display("FAIL basic_latency: got %0d, required 4", lat); end
        n_checks++;
        if (x !== 12'h400) begin n_fail++; $display("FAIL basic_sum: got %03h, required 400", x); end
        n_checks++;
        if (of !== 1'b0 || uf !== 1'b0) begin
            n_fail++; $display("FAIL basic_flags: got of=%b uf=%b, required 0 0", of, uf);
        end
    endtask

    task automatic test_cancel_and_zero();
        int lat; logic [11:0] x, xt; logic of, uf;
        op(12'h3C0, 12'h3C0, 1'b1, lat, x, of, uf, xt);
        n_checks++;
        if (x !== 12'h000 || of !== 1'b0 || uf !== 1'b0) begin
            n_fail++; $display("FAIL cancel: got x=%03h of=%b uf=%b, required 000 0 0", x, of, uf);
        end
        op(12'h000, 12'hBC0, 1'b1, lat, x, of, uf, xt);
        n_checks++;
        if (x !== 12'h3C0) begin n_fail++; $display("FAIL zero_operand: got %03h, required 3C0", x); end
        op(12'h000, 12'h000, 1'b0, lat, x, of, uf, xt);
        n_checks++;
        if (x !== 12'h000 || of !== 1'b0 || uf !== 1'b0) begin
            n_fail++; $display("FAIL both_zero: got x=%03h of=%b uf=%b, required 000 0 0", x, of, uf);
        end
    endtask

    task automatic test_rounding();
        int lat; logic [11:0] x, xt; logic of, uf;
        op(12'h3C0, 12'h200, 1'b0, lat, x, of, uf, xt);
        n_checks++;
        if (x !== 12'h3C0) begin n_fail++; $display("FAIL round_tie: got %03h, required 3C0", x); end
        op(12'h3C0, 12'h220, 1'b0, lat, x, of, uf, xt);
        n_checks++;
        if (x !== 12'h3C1) begin n_fail++; $display("FAIL round_up: got %03h, required 3C1", x); end
        n_checks++;
        if (xt !== 12'h3C0) begin n_fail++; $display("FAIL trunc_drop: got %03h, required 3C0", xt); end
        op(12'h3FF, 12'h220, 1'b0, lat, x, of, uf, xt);
        n_checks++;
        if (x !== 12'h400) begin n_fail++; $display("FAIL round_carry: got %03h, required 400", x); end
        n_checks++;
        if (xt !== 12'h3FF) begin n_fail++; $display("FAIL trunc_carry: got %03h, required 3FF", xt); end
    endtask

    task automatic test_limits();
        int lat; logic [11:0] x, xt; logic of, uf;
        op(12'h7FF, 12'h7FF, 1'b0, lat, x, of, uf, xt);
        n_checks++;
        if (x !== 12'h7FF || of !== 1'b1 || uf !== 1'b0) begin
            n_fail++; $display("FAIL overflow: got x=%03h of=%b uf=%b, required 7FF 1 0", x, of, uf);
        end
        op(12'h041, 12'h840, 1'b0, lat, x, of, uf, xt);
        n_checks++;
        if (x !== 12'h000 || of !== 1'b0 || uf !== 1'b1) begin
            n_fail++; $display("FAIL underflow: got x=%03h of=%b uf=%b, required 000 0 1", x, of, uf);
        end
        // Flags must drop as soon as out_valid does.
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || underflow !== 1'b0) begin
            n_fail++; $display("FAIL flag_clear: got v=%b uf=%b, required 0 0", out_valid, underflow);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] a_v [6] = '{12'h3C0, 12'h400, 12'h3C0, 12'h400, 12'h3C0, 12'h3FF};
        logic [11:0] b_v [6] = '{12'h3C0, 12'h3C0, 12'h3C0, 12'h3C0, 12'h220, 12'h220};
        logic        s_v [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [11:0] x_v [6] = '{12'h400, 12'h420, 12'h000, 12'h3C0, 12'h3C1, 12'h400};
        logic        vpat [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int in_idx = 0;
        int out_idx = 0;
        logic exp_v;
        logic [11:0] held = '0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (c < 8 && vpat[c]) begin
                in_valid = 1'b1; fp_a = a_v[in_idx]; fp_b = b_v[in_idx]; sub = s_v[in_idx];
                in_idx++;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            exp_v = (c >= 4 && c < 12) ? vpat[c-4] : 1'b0;
            n_checks++;
            if (out_valid !== exp_v) begin
                n_fail++; $display("FAIL stream_valid[%0d]: got %b, required %b", c, out_valid, exp_v);
            end
            if (exp_v) begin
                n_checks++;
                if (fp_x !== x_v[out_idx]) begin
                    n_fail++; $display("FAIL stream_data[%0d]: got %03h, required %03h", out_idx, fp_x, x_v[out_idx]);
                end
                $display("stream result %0d x=%03h", out_idx, fp_x);
                held = x_v[out_idx];
                out_idx++;
            end else if (out_idx > 0) begin
                n_checks++;
                if (fp_x !== held) begin
                    n_fail++; $display("FAIL stream_hold[%0d]: got %03h, required %03h", c, fp_x, held);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        int lat; logic [11:0] x, xt; logic of, uf;
        int seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            in_valid = 1'b1; fp_a = 12'h3C0; fp_b = 12'h3C0; sub = 1'b0;
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || fp_x !== 12'h000 || overflow !== 1'b0 || underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL midflight_reset: got v=%b x=%03h of=%b uf=%b, required all 0",
                     out_valid, fp_x, overflow, underflow);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        repeat (10) begin @(posedge clk); #1; if (out_valid !== 1'b0) seen++; end
        n_checks++;
        if (seen != 0) begin
            n_fail++; $display("FAIL stale_valid: got %0d valid cycles, required 0", seen);
        end
        $display("midflight reset: stale valid cycles=%0d", seen);
        op(12'h400, 12'h3C0, 1'b0, lat, x, of, uf, xt);
        n_checks++;
        if (lat !== 4 || x !== 12'h420) begin
            n_fail++; $display("FAIL post_reset_op: got lat=%0d x=%03h, required 4 420", lat, x);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_cancel_and_zero();
        test_rounding();
        test_limits();
        test_back_to_back();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/float_add_pipe.md
Name: float_add_pipe

Overview:
- Parametrised, valid-qualified successor to the 12-bit float adder.
- Adds or subtracts two custom-format floats (sign | biased exponent | fraction with hidden 1) through a fixed 4-stage pipeline.
- Provides selectable round-to-nearest-even or truncation, and overflow/underflow flags.
- Sits in the neuron accumulate datapath; one operation per clock, no backpressure.

Parameters:
- EXP_W, 5, exponent field width; bias = 2^(EXP_W-1)-1.
- MAN_W, 6, fraction field width (hidden bit not stored).
- ROUND_EN, 1, 1 = round-to-nearest-even; 0 = truncate (legacy-compatible).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operands valid this cycle.
- sub  in  1  0: x = a+b; 1: x = a-b (sign of b inverted at input).
- fp_a  in  1+EXP_W+MAN_W  operand A {sgn, exp, frac}.
- fp_b  in  1+EXP_W+MAN_W  operand B.
- out_valid  out  1  fp_x/flags valid.
- fp_x  out  1+EXP_W+MAN_W  result.
- overflow  out  1  result saturated this output.
- underflow  out  1  nonzero result flushed to zero.

Behaviour:
- Format:
  - exp==0 means zero; frac is ignored and the sign is ignored.
  - No denormals, inf or NaN. exp all-ones is an ordinary normal exponent.
  - Any zero result is encoded all-zeros (+0).
- Reset:
  - out_valid, fp_x, overflow, underflow, and all stage valids/registers are 0.
  - Reset mid-operation discards in-flight ops. No out_valid until a new in_valid is presented, then 4 cycles later.
- Latency and throughput:
  - Operands sampled at edge N when in_valid=1; result presented after edge N+4 with out_valid=1.
  - Fully pipelined, 1 op/cycle. Results emerge in input order.
  - Each stage register loads only when its incoming valid=1, otherwise it holds.
  - When out_valid=0, fp_x and flags hold their last values.
- S1 (compare):
  - Apply sub to b's sign.
  - Order operands by magnitude ({exp,frac} compare); the larger magnitude is L, the other is S.
  - diff = expL-expS; effective op = subtract when signs differ; result sign = sign of L.
  - A zero operand (exp==0) has significand 0.
- S2 (align):
  - Extend significands to {1,frac,G,R,St}.
  - Right-shift S by diff; bits shifted past St OR into St.
  - diff >= MAN_W+3 leaves S = sticky-only (St=1 if S nonzero).
- S3 (add):
  - MAN_W+5-bit add/sub of L and aligned S. Computing S-L is not permitted, since L >= S.
  - Compute leading-zero count of the sum.
- S4 (normalise/round/pack):
  - Carry-out: right-shift 1, exp+1, shifted-out bit ORs into St.
  - Otherwise: left-shift by lzc, exp-lzc.
  - ROUND_EN=1: increment when G & (R|St|lsb). ROUND_EN=0: drop G/R/St.
  - A rounding carry out of the significand gives exp+1, frac=0.
  - Zero sum (exact cancellation, or both operands zero): fp_x=0, no flags.
  - Final exp > 2^EXP_W-1: fp_x = {sgn, all-ones exp, all-ones frac}, overflow=1.
  - Final exp <= 0 with nonzero sum: fp_x=0, underflow=1.
  - Flags are per-result and are 0 whenever out_valid=0.
- Width rule: exponent arithmetic is carried in EXP_W+2-bit signed intermediates so that overflow and underflow are detectable.

Test Plan (defaults EXP_W=5, MAN_W=6):
- Basic add: in_valid=1, fp_a=0x3C0 (1.0), fp_b=0x3C0, sub=0.
  - Expect out_valid=1 exactly 4 cycles later, fp_x=0x400 (2.0), flags 0.
- Cancellation: fp_a=0x3C0, fp_b=0x3C0, sub=1 -> fp_x=0x000, flags 0.
- Zero operand: fp_a=0x000, fp_b=0xBC0, sub=1 -> fp_x=0x3C0.
- Rounding, ROUND_EN=1:
  - 0x3C0+0x200 (1+2^-7, exact tie) -> 0x3C0.
  - 0x3C0+0x220 (above half) -> 0x3C1.
  - 0x3FF+0x220 -> 0x400 (rounding carry into exponent).
- Rounding, ROUND_EN=0: 0x3C0+0x220 -> 0x3C0.
- Limits:
  - 0x7FF+0x7FF -> fp_x=0x7FF, overflow=1.
  - 0x041-0x040 (sub=0 with fp_b=0x840) -> fp_x=0x000, underflow=1.
- Streaming and reset:
  - 4 back-to-back valid ops, a 2-cycle gap, then 2 more -> 6 results in order, with the same gap on out_valid, and fp_x held during the gap.
  - Assert reset_n=0 with 3 ops in flight -> outputs 0 immediately and no stale out_valid after release.
